// File: rtl/p_serial_transposer.sv
// p_serial_transposer: P-side end of the sen/sd serial link.
// Down phase collects column frames into RB2; up phase reads RB2 back
// transposed and sends one frame per row.
module p_serial_transposer #(
  parameter int unsigned NCOL = 8,
  parameter int unsigned NROW = 18,
  parameter int unsigned CW   = 3,
  parameter int unsigned RW   = 5,
  parameter int unsigned DW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            updown,
  output logic            P_done,
  output logic            RB2_RW,
  output logic [CW-1:0]   RB2_A,
  output logic [NROW-1:0] RB2_D,
  input  logic [NROW-1:0] RB2_Q,
  inout  wire             sen,
  inout  wire             sd
);

  localparam int unsigned FW  = CW + NROW;        // down-frame length
  localparam int unsigned TW  = RW + DW;          // up-frame length
  localparam int unsigned BCW = $clog2(FW + 1);
  localparam int unsigned CCW = $clog2(NCOL + 1);
  localparam int unsigned GCW = $clog2(NCOL + 1);
  localparam int unsigned SCW = $clog2(TW);
  localparam int unsigned DIW = $clog2(DW);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RX_FRAME  = 3'd1;
  localparam logic [2:0] S_RX_WRITE  = 3'd2;
  localparam logic [2:0] S_RX_DONE   = 3'd3;
  localparam logic [2:0] S_TX_GATHER = 3'd4;
  localparam logic [2:0] S_TX_SHIFT  = 3'd5;
  localparam logic [2:0] S_TX_DONE   = 3'd6;

  logic [2:0]      r_state,   w_state_nxt;
  logic            r_sen_r,   r_sd_r;
  logic [FW-1:0]   r_shift,   w_shift_nxt;
  logic [BCW-1:0]  r_bitcnt,  w_bitcnt_nxt;
  logic [CCW-1:0]  r_colcnt,  w_colcnt_nxt;
  logic [RW-1:0]   r_row,     w_row_nxt;
  logic [DW-1:0]   r_data,    w_data_nxt;
  logic [GCW-1:0]  r_gcnt,    w_gcnt_nxt;
  logic [SCW-1:0]  r_scnt,    w_scnt_nxt;
  logic            r_p_done,  w_p_done_nxt;
  logic            r_rb2_rw,  w_rb2_rw_nxt;
  logic [CW-1:0]   r_rb2_a,   w_rb2_a_nxt;
  logic [NROW-1:0] r_rb2_d,   w_rb2_d_nxt;
  logic            r_sen_out, w_sen_out_nxt;
  logic            r_sd_out,  w_sd_out_nxt;

  logic [BCW-1:0]  w_bitcnt_inc;
  logic [CCW-1:0]  w_colcnt_inc;
  logic [DIW-1:0]  w_cap_idx;
  logic [SCW-1:0]  w_sd_idx;
  logic [TW-1:0]   w_frame;

  assign w_bitcnt_inc = r_bitcnt + BCW'(1);
  assign w_colcnt_inc = r_colcnt + CCW'(1);
  // Read data for address (gcnt-1) arrives during gather step gcnt.
  assign w_cap_idx    = DIW'(GCW'(NCOL) - r_gcnt);
  assign w_sd_idx     = SCW'(TW - 1) - r_scnt;
  assign w_frame      = {r_row, r_data};

  assign P_done = r_p_done;
  assign RB2_RW = r_rb2_rw;
  assign RB2_A  = r_rb2_a;
  assign RB2_D  = r_rb2_d;

  // P owns the link wires only while it is the transmitter.
  assign sen = updown ? r_sen_out : 1'bz;
  assign sd  = updown ? r_sd_out  : 1'bz;

  // State, counters, input sync and registered outputs; falling-edge clocked.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sen_r   <= 1'b1;
      r_sd_r    <= 1'b0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_colcnt  <= '0;
      r_row     <= '0;
      r_data    <= '0;
      r_gcnt    <= '0;
      r_scnt    <= '0;
      r_p_done  <= 1'b0;
      r_rb2_rw  <= 1'b1;
      r_rb2_a   <= '0;
      r_rb2_d   <= '0;
      r_sen_out <= 1'b1;
      r_sd_out  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sen_r   <= sen;
      r_sd_r    <= sd;
      r_shift   <= w_shift_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_colcnt  <= w_colcnt_nxt;
      r_row     <= w_row_nxt;
      r_data    <= w_data_nxt;
      r_gcnt    <= w_gcnt_nxt;
      r_scnt    <= w_scnt_nxt;
      r_p_done  <= w_p_done_nxt;
      r_rb2_rw  <= w_rb2_rw_nxt;
      r_rb2_a   <= w_rb2_a_nxt;
      r_rb2_d   <= w_rb2_d_nxt;
      r_sen_out <= w_sen_out_nxt;
      r_sd_out  <= w_sd_out_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bitcnt_nxt  = r_bitcnt;
    w_colcnt_nxt  = r_colcnt;
    w_row_nxt     = r_row;
    w_data_nxt    = r_data;
    w_gcnt_nxt    = r_gcnt;
    w_scnt_nxt    = r_scnt;
    w_p_done_nxt  = 1'b0;
    w_rb2_rw_nxt  = 1'b1;
    w_rb2_a_nxt   = r_rb2_a;
    w_rb2_d_nxt   = r_rb2_d;
    w_sen_out_nxt = 1'b1;
    w_sd_out_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (updown) begin
          w_state_nxt = S_TX_GATHER;
          w_row_nxt   = '0;
          w_gcnt_nxt  = '0;
        end else begin
          w_state_nxt  = S_RX_FRAME;
          w_bitcnt_nxt = '0;
        end
      end

      S_RX_FRAME: begin
        if (updown) begin
          // Any partial frame is dropped when the direction flips.
          w_state_nxt  = S_TX_GATHER;
          w_bitcnt_nxt = '0;
          w_row_nxt    = '0;
          w_gcnt_nxt   = '0;
        end else if (!r_sen_r) begin
          w_shift_nxt  = {r_shift[FW-2:0], r_sd_r};
          w_bitcnt_nxt = w_bitcnt_inc;
          if (w_bitcnt_inc == BCW'(FW)) begin
            w_state_nxt = S_RX_WRITE;
          end
        end else begin
          w_bitcnt_nxt = '0;
        end
      end

      S_RX_WRITE: begin
        w_rb2_rw_nxt = 1'b0;
        w_rb2_a_nxt  = r_shift[FW-1 -: CW];
        w_rb2_d_nxt  = r_shift[NROW-1:0];
        w_colcnt_nxt = w_colcnt_inc;
        w_bitcnt_nxt = '0;
        w_state_nxt  = (w_colcnt_inc == CCW'(NCOL)) ? S_RX_DONE : S_RX_FRAME;
      end

      S_RX_DONE: begin
        if (updown) begin
          w_state_nxt = S_TX_GATHER;
          w_row_nxt   = '0;
          w_gcnt_nxt  = '0;
        end
      end

      S_TX_GATHER: begin
        if (!updown) begin
          w_state_nxt  = S_RX_FRAME;
          w_bitcnt_nxt = '0;
          w_colcnt_nxt = '0;
        end else begin
          if (r_gcnt < GCW'(NCOL)) begin
            w_rb2_a_nxt = CW'(r_gcnt);
          end
          if (r_gcnt != '0) begin
            w_data_nxt[w_cap_idx] = RB2_Q[r_row];
          end
          if (r_gcnt == GCW'(NCOL)) begin
            w_state_nxt = S_TX_SHIFT;
            w_scnt_nxt  = '0;
          end else begin
            w_gcnt_nxt = r_gcnt + GCW'(1);
          end
        end
      end

      S_TX_SHIFT: begin
        if (!updown) begin
          w_state_nxt  = S_RX_FRAME;
          w_bitcnt_nxt = '0;
          w_colcnt_nxt = '0;
        end else begin
          w_sen_out_nxt = 1'b0;
          w_sd_out_nxt  = w_frame[w_sd_idx];
          if (r_scnt == SCW'(TW - 1)) begin
            if (r_row == RW'(NROW - 1)) begin
              w_state_nxt = S_TX_DONE;
            end else begin
              w_row_nxt   = r_row + RW'(1);
              w_gcnt_nxt  = '0;
              w_state_nxt = S_TX_GATHER;
            end
          end else begin
            w_scnt_nxt = r_scnt + SCW'(1);
          end
        end
      end

      S_TX_DONE: begin
        if (!updown) begin
          w_state_nxt  = S_RX_FRAME;
          w_colcnt_nxt = '0;
          w_bitcnt_nxt = '0;
        end else begin
          w_p_done_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_p_serial_transposer.sv
// Directed bench for p_serial_transposer: models RB2 as a clocked RAM,
// plays the S side of the link and decodes P's up-frames.
module tb_p_serial_transposer;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        updown = 1'b0;
  logic        tb_sen = 1'b1;
  logic        tb_sd  = 1'b0;
  wire         sen;
  wire         sd;
  logic        P_done;
  logic        RB2_RW;
  logic [2:0]  RB2_A;
  logic [17:0] RB2_D;
  logic [17:0] rb2_q = '0;

  logic        pl_we = 1'b0;
  logic [2:0]  pl_a  = '0;
  logic [17:0] pl_d  = '0;
  logic [17:0] mem [8];

  int          wr_cnt = 0;
  logic [2:0]  wa_log [64];
  logic [17:0] wd_log [64];

  int          fr_cnt = 0;
  logic [12:0] fr_log  [64];
  int          len_log [64];
  int          gap_log [64];
  logic [12:0] m_sh   = '0;
  int          m_bits = 0;
  int          m_gap  = 0;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          base;
  logic [7:0]  exp_d;
  logic [7:0]  early_exp [6];

  always #5 clk = ~clk;

  // S side drives the link only in the down direction.
  assign sen = updown ? 1'bz : tb_sen;
  assign sd  = updown ? 1'bz : tb_sd;

  p_serial_transposer dut (
    .clk    (clk),
    .rst    (rst),
    .updown (updown),
    .P_done (P_done),
    .RB2_RW (RB2_RW),
    .RB2_A  (RB2_A),
    .RB2_D  (RB2_D),
    .RB2_Q  (rb2_q),
    .sen    (sen),
    .sd     (sd)
  );

  // RB2 model: synchronous RAM on the rising edge, plus a write log.
  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_a] <= pl_d;
    end else if (RB2_RW == 1'b0) begin
      mem[RB2_A]          <= RB2_D;
      wa_log[wr_cnt[5:0]] <= RB2_A;
      wd_log[wr_cnt[5:0]] <= RB2_D;
      wr_cnt              <= wr_cnt + 1;
    end
    rb2_q <= mem[RB2_A];
  end

  // Up-frame decoder: collects sen-low bursts and the high gap before each.
  always @(posedge clk) begin
    if (rst || !updown) begin
      m_bits <= 0;
      m_gap  <= 0;
    end else if (sen === 1'b0) begin
      m_sh   <= {m_sh[11:0], sd};
      m_bits <= m_bits + 1;
      if (m_bits == 0) begin
        gap_log[fr_cnt[5:0]] <= m_gap;
        m_gap                <= 0;
      end
    end else begin
      m_gap <= m_gap + 1;
      if (m_bits != 0) begin
        fr_log[fr_cnt[5:0]]  <= m_sh;
        len_log[fr_cnt[5:0]] <= m_bits;
        fr_cnt               <= fr_cnt + 1;
        m_bits               <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Sends the first n bits of {col, payload}, then idles the link.
  task automatic send_bits(input logic [2:0] col, input logic [17:0] pay, input int n);
    logic [20:0] f;
    f = {col, pay};
    for (int i = 0; i < n; i++) begin
      tick();
      tb_sen = 1'b0;
      tb_sd  = f[5'(20 - i)];
    end
    tick();
    tb_sen = 1'b1;
    tb_sd  = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && fr_cnt < target; i++) tick();
    check(tag, 32'(fr_cnt >= target), 32'd1);
  endtask

  task automatic wait_sen_low(input string tag, input int budget);
    for (int i = 0; i < budget && sen !== 1'b0; i++) tick();
    check(tag, 32'(sen === 1'b0), 32'd1);
  endtask

  initial begin
    early_exp = '{8'h85, 8'h51, 8'h25, 8'h11, 8'h09, 8'h11};

    // Reset values.
    repeat (3) tick();
    check("rst_p_done", 32'(P_done), 32'd0);
    check("rst_rw",     32'(RB2_RW), 32'd1);
    check("rst_addr",   32'(RB2_A),  32'd0);
    check("rst_wdata",  32'(RB2_D),  32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Full down phase: word c = 3FFFF >> c, columns in order.
    base = wr_cnt;
    for (int c = 0; c < 8; c++) send_bits(3'(c), 18'h3FFFF >> c, 21);
    repeat (3) tick();
    check("down_wr_count", 32'(wr_cnt - base), 32'd8);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("down_addr%0d", c),  32'(wa_log[6'(base + c)]), 32'(c));
      check($sformatf("down_wdata%0d", c), 32'(wd_log[6'(base + c)]), 32'(18'h3FFFF >> c));
    end
    // Block complete: further frames are ignored.
    send_bits(3'd2, 18'h15555, 21);
    check("rxdone_no_write", 32'(wr_cnt - base), 32'd8);

    // Full up phase with word c = 1 << c.
    for (int c = 0; c < 8; c++) begin
      pl_we = 1'b1;
      pl_a  = 3'(c);
      pl_d  = 18'h00001 << c;
      tick();
    end
    pl_we = 1'b0;
    tick();
    base   = fr_cnt;
    updown = 1'b1;
    wait_frames("up_wait", base + 18, 600);
    for (int r = 0; r < 18; r++) begin
      exp_d = (r < 8) ? (8'h80 >> r) : 8'h00;
      check($sformatf("up_len%0d", r),   32'(len_log[6'(base + r)]), 32'd13);
      check($sformatf("up_frame%0d", r), 32'(fr_log[6'(base + r)]),  32'({5'(r), exp_d}));
      if (r > 0) check($sformatf("up_gap%0d", r), 32'(gap_log[6'(base + r)]), 32'd9);
    end
    check("up_p_done_set", 32'(P_done), 32'd1);
    updown = 1'b0;
    tick();
    check("up_p_done_clr", 32'(P_done), 32'd0);
    repeat (2) tick();

    // Aborted partial frame, then a valid column-5 frame.
    base = wr_cnt;
    send_bits(3'd5, 18'h3FFFF, 10);
    send_bits(3'd5, 18'h12345, 21);
    check("abort_wr_count", 32'(wr_cnt - base), 32'd1);
    check("abort_addr",     32'(wa_log[6'(base)]), 32'd5);
    check("abort_wdata",    32'(wd_log[6'(base)]), 32'h12345);

    // Single frame: column 3, payload 2AAAA.
    base = wr_cnt;
    send_bits(3'd3, 18'h2AAAA, 21);
    check("single_wr_count", 32'(wr_cnt - base), 32'd1);
    check("single_addr",     32'(wa_log[6'(base)]), 32'd3);
    check("single_wdata",    32'(wd_log[6'(base)]), 32'h2AAAA);

    // Two more frames (four in this phase), then turn the link early.
    send_bits(3'd6, 18'h00000, 21);
    send_bits(3'd7, 18'h3FFFF, 21);
    base   = fr_cnt;
    updown = 1'b1;
    wait_frames("early_wait", base + 6, 300);
    for (int r = 0; r < 6; r++) begin
      check($sformatf("early_frame%0d", r), 32'(fr_log[6'(base + r)]), 32'({5'(r), early_exp[r]}));
    end
    wait_sen_low("early_row6_start", 40);
    repeat (5) tick();
    updown = 1'b0;
    repeat (4) tick();
    check("early_no_row6", 32'(fr_cnt - base), 32'd6);
    check("early_p_done",  32'(P_done), 32'd0);

    // Asynchronous reset in the middle of row 3.
    base   = fr_cnt;
    updown = 1'b1;
    wait_frames("rst_wait", base + 3, 300);
    wait_sen_low("rst_row3_start", 40);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("arst_p_done", 32'(P_done), 32'd0);
    check("arst_rw",     32'(RB2_RW), 32'd1);
    check("arst_addr",   32'(RB2_A),  32'd0);
    check("arst_wdata",  32'(RB2_D),  32'd0);
    check("arst_sen",    32'(sen),    32'd1);
    check("arst_sd",     32'(sd),     32'd0);
    tick();
    rst  = 1'b0;
    base = fr_cnt;
    wait_frames("restart_wait", base + 1, 100);
    check("restart_len",   32'(len_log[6'(base)]), 32'd13);
    check("restart_frame", 32'(fr_log[6'(base)]),  32'({5'd0, 8'h85}));

    updown = 1'b0;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
